// File: rtl/icb_scratch_pkg.sv
// icb_scratch_pkg
// Shared types and helpers for the ICB scratch-register target.
//   rsp_t      : one queued response {err, rdata}
//   RSP_W      : packed width of rsp_t
//   idxw_f     : register-index width for a given register count
//   byte_merge : byte-masked update of a 32-bit word
package icb_scratch_pkg;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   localparam int RSP_W = $bits(rsp_t);

   // Index width derived from the register count (IDXW = log2(NREG)).
   function automatic int idxw_f(input int nreg);
      return $clog2(nreg);
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wmask);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (wmask[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/icb_scratch_rsp_fifo.sv
// icb_scratch_rsp_fifo
// Synchronous outstanding-response FIFO. Head entry is presented on dout.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, din       : enqueue (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   dout            : head entry
//   full, empty     : status
//   count           : occupancy, log2(OUTS_DEPTH)+1 bits
module icb_scratch_rsp_fifo #(
   parameter  int OUTS_DEPTH = 2,
   parameter  int WIDTH      = 33,
   localparam int PW         = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1,
   localparam int CW         = $clog2(OUTS_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [OUTS_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(OUTS_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < OUTS_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == PW'(OUTS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(OUTS_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/icb_scratch_slave.sv
// icb_scratch_slave
// ICB target backed by NREG 32-bit scratch registers with byte-masked writes
// and an in-order outstanding-response FIFO.
// Optional feature macro: ICB_SCRATCH_ERR_EN
//   defined   : window miss or misaligned address -> err=1, rdata=0, no write
//   undefined : no decode; index from low address bits, err always 0
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   icb_cmd_valid/ready         : command handshake
//   icb_cmd_addr/read/wdata/wmask : command payload
//   icb_rsp_valid/ready         : response handshake
//   icb_rsp_err/rdata           : response payload (rdata 0 for writes/errors)
import icb_scratch_pkg::*;

module icb_scratch_slave #(
   parameter int            AW         = 32,
   parameter int            NREG       = 8,
   parameter logic [AW-1:0] BASE_ADDR  = 32'h1000_0000,
   parameter int            OUTS_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          icb_cmd_valid,
   output logic          icb_cmd_ready,
   input  logic [AW-1:0] icb_cmd_addr,
   input  logic          icb_cmd_read,
   input  logic [31:0]   icb_cmd_wdata,
   input  logic [3:0]    icb_cmd_wmask,
   output logic          icb_rsp_valid,
   input  logic          icb_rsp_ready,
   output logic          icb_rsp_err,
   output logic [31:0]   icb_rsp_rdata
);

   localparam int IDXW = idxw_f(NREG);
   localparam int CW   = $clog2(OUTS_DEPTH) + 1;

   logic [31:0]     regs [NREG];
   logic [IDXW-1:0] idx;
   logic            cmd_err;
   logic            accept;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   unused_count;
   rsp_t            push_rsp;
   rsp_t            head_rsp;

   assign idx = icb_cmd_addr[IDXW+1:2];

`ifdef ICB_SCRATCH_ERR_EN
   assign cmd_err = (icb_cmd_addr[AW-1:IDXW+2] != BASE_ADDR[AW-1:IDXW+2]) |
                    (icb_cmd_addr[1:0] != 2'b00);
`else
   // Window aliases over the whole port: upper and byte-offset bits are ignored.
   logic unused_addr;
   assign unused_addr = ^{icb_cmd_addr[AW-1:IDXW+2], icb_cmd_addr[1:0], BASE_ADDR};
   assign cmd_err     = 1'b0;
`endif

   // Ready only reflects registered occupancy; a pop while full frees a slot
   // for the next cycle, not this one.
   assign icb_cmd_ready = ~fifo_full;
   assign accept        = icb_cmd_valid & icb_cmd_ready;
   assign icb_rsp_valid = ~fifo_empty;
   assign pop           = icb_rsp_valid & icb_rsp_ready;

   always_comb begin
      push_rsp.err   = cmd_err;
      push_rsp.rdata = '0;
      if (icb_cmd_read && !cmd_err) push_rsp.rdata = regs[idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (accept && !icb_cmd_read && !cmd_err) begin
         regs[idx] <= byte_merge(regs[idx], icb_cmd_wdata, icb_cmd_wmask);
      end
   end

   icb_scratch_rsp_fifo #(
      .OUTS_DEPTH (OUTS_DEPTH),
      .WIDTH      (RSP_W)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (push_rsp),
      .pop   (pop),
      .dout  (head_rsp),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (unused_count)
   );

   // Gate with valid so an empty FIFO shows zeros rather than a stale head.
   assign icb_rsp_err   = icb_rsp_valid & head_rsp.err;
   assign icb_rsp_rdata = icb_rsp_valid ? head_rsp.rdata : 32'h0;

endmodule
